// File: rtl/cpu_speed_ctrl_if.sv
// Bundle of reset requests, speed/pause controls and the resulting core
// reset and clock-enable outputs exchanged between top level and cpu_speed_ctrl.
interface cpu_speed_ctrl_if #(
    parameter int NUM_RST_SRC = 2,
    parameter int SPEED_W     = 2
);
    logic [NUM_RST_SRC-1:0] rst_src;
    logic [SPEED_W-1:0]     speed_sel;
    logic                   pause;
    logic                   reset_out;
    logic                   cpu_ce;
    logic [SPEED_W-1:0]     speed_active;

    modport master (
        output rst_src, speed_sel, pause,
        input  reset_out, cpu_ce, speed_active
    );

    modport slave (
        input  rst_src, speed_sel, pause,
        output reset_out, cpu_ce, speed_active
    );
endinterface

// File: rtl/cpu_speed_ctrl.sv
// Core control: synchronised and stretched core reset, run-time selectable
// CPU clock-enable divider that switches only on period boundaries, pause gate.
module cpu_speed_ctrl #(
    parameter int NUM_RST_SRC = 2,
    parameter int SPEED_W     = 2,
    parameter int RST_STRETCH = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    cpu_speed_ctrl_if.slave  bus
);

    localparam logic [1:0] S_RST     = 2'd0;
    localparam logic [1:0] S_STRETCH = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(RST_STRETCH - 1);

    logic [NUM_RST_SRC-1:0] src_s1_q, src_s2_q;
    logic [SPEED_W-1:0]     spd_s1_q, spd_s2_q;
    logic                   pause_s1_q, pause_s2_q;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rst_out_q, rst_out_d;
    logic [SPEED_W-1:0]     div_cnt_q, div_cnt_d;
    logic [SPEED_W-1:0]     div_cur_q, div_cur_d;
    logic                   ce_q, ce_d;

    logic                   src_any;
    logic                   gate;

    assign src_any = |src_s2_q;
    // Pause cannot stop the enable while the core is in reset: its
    // synchronous reset logic must keep being clocked.
    assign gate    = pause_s2_q & ~rst_out_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RST: begin
                if (!src_any) begin
                    cnt_d   = STRETCH_LOAD;
                    state_d = S_STRETCH;
                end
            end
            S_STRETCH: begin
                if (src_any)           state_d = S_RST;
                else if (cnt_q == '0)  state_d = S_RUN;
                else                   cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RUN: begin
                if (src_any) state_d = S_RST;
            end
            default: state_d = S_RST;
        endcase
        rst_out_d = (state_d != S_RUN);
    end

    // The divisor is only taken from the synchroniser at a period boundary,
    // so a speed change never produces a short or long period.
    always_comb begin
        div_cnt_d = div_cnt_q;
        div_cur_d = div_cur_q;
        ce_d      = 1'b0;
        if (!gate) begin
            if (div_cnt_q == div_cur_q) begin
                ce_d      = 1'b1;
                div_cnt_d = '0;
                div_cur_d = spd_s2_q;
            end else begin
                div_cnt_d = div_cnt_q + SPEED_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            src_s1_q   <= '0;
            src_s2_q   <= '0;
            spd_s1_q   <= '0;
            spd_s2_q   <= '0;
            pause_s1_q <= 1'b0;
            pause_s2_q <= 1'b0;
            state_q    <= S_RST;
            cnt_q      <= '0;
            rst_out_q  <= 1'b1;
            div_cnt_q  <= '0;
            div_cur_q  <= '0;
            ce_q       <= 1'b0;
        end else begin
            src_s1_q   <= bus.rst_src;
            src_s2_q   <= src_s1_q;
            spd_s1_q   <= bus.speed_sel;
            spd_s2_q   <= spd_s1_q;
            pause_s1_q <= bus.pause;
            pause_s2_q <= pause_s1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_out_q  <= rst_out_d;
            div_cnt_q  <= div_cnt_d;
            div_cur_q  <= div_cur_d;
            ce_q       <= ce_d;
        end
    end

    assign bus.reset_out    = rst_out_q;
    assign bus.cpu_ce       = ce_q;
    assign bus.speed_active = div_cur_q;

endmodule

// File: tb/tb_cpu_speed_ctrl.sv
// Directed bench for cpu_speed_ctrl with a cycle model compared every clock.
module tb_cpu_speed_ctrl;

    localparam int NSRC = 2;
    localparam int SW   = 2;
    localparam int STR  = 16;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    cpu_speed_ctrl_if #(.NUM_RST_SRC(NSRC), .SPEED_W(SW)) bus ();

    cpu_speed_ctrl #(
        .NUM_RST_SRC(NSRC),
        .SPEED_W    (SW),
        .RST_STRETCH(STR),
        .CNT_W      (16)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: reset output is low only once the synchronised request has been
    // quiet for more than RST_STRETCH consecutive edges; the enable fires once
    // every (divisor+1) ungated cycles, picking up a new divisor at each pulse.
    logic [NSRC-1:0] m_src1, m_src2;
    int              m_spd1, m_spd2;
    bit              m_pause1, m_pause2;
    int              m_quiet;
    bit              m_rout, m_ce, m_gate;
    int              m_cur, m_since;

    always @(posedge clk_sys) begin
        if (!reset_n) begin
            m_src1 = '0; m_src2 = '0;
            m_spd1 = 0;  m_spd2 = 0;
            m_pause1 = 0; m_pause2 = 0;
            m_quiet = 0; m_rout = 1; m_ce = 0;
            m_cur = 0;   m_since = 0;
        end else begin
            m_gate = m_pause2 && !m_rout;
            if (m_gate) begin
                m_ce = 0;
            end else if (m_since + 1 == m_cur + 1) begin
                m_ce = 1; m_since = 0; m_cur = m_spd2;
            end else begin
                m_ce = 0; m_since++;
            end
            if (m_src2 != 0)      m_quiet = 0;
            else if (m_quiet < 1000) m_quiet++;
            m_rout   = (m_quiet <= STR);
            m_src2   = m_src1;   m_src1   = bus.rst_src;
            m_spd2   = m_spd1;   m_spd1   = int'(bus.speed_sel);
            m_pause2 = m_pause1; m_pause1 = bus.pause;
        end
        #1;
        check("model_reset_out", bus.reset_out, m_rout);
        check("model_cpu_ce", bus.cpu_ce, m_ce);
        check("model_speed_active", bus.speed_active, m_cur);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    int cnt;
    bit found;

    initial begin
        bus.rst_src   = '0;
        bus.speed_sel = '0;
        bus.pause     = 1'b0;
        reset_n       = 1'b0;

        // Power-on
        tick(5);
        check("por_reset_state", bus.reset_out, 1);
        check("por_ce_state", bus.cpu_ce, 0);
        reset_n = 1'b1;
        tick(16);
        check("por_hold16", bus.reset_out, 1);
        check("por_ce_in_reset", bus.cpu_ce, 1);
        tick(1);
        check("por_release17", bus.reset_out, 0);
        tick(5);

        // Button pulse on rst_src[1]
        bus.rst_src = 2'b10;
        tick(2);
        check("btn_lat2", bus.reset_out, 0);
        tick(1);
        check("btn_lat3", bus.reset_out, 1);
        tick(1);
        bus.rst_src = 2'b00;
        tick(18);
        check("btn_stretch_hold", bus.reset_out, 1);
        tick(1);
        check("btn_fall", bus.reset_out, 0);
        tick(3);

        // Re-trigger during stretch
        bus.rst_src = 2'b01;
        tick(1);
        bus.rst_src = 2'b00;
        tick(3);
        tick(9);
        bus.rst_src = 2'b01;
        tick(1);
        bus.rst_src = 2'b00;
        tick(6);
        check("retrig_hold", bus.reset_out, 1);
        tick(12);
        check("retrig_hold_last", bus.reset_out, 1);
        tick(1);
        check("retrig_fall", bus.reset_out, 0);
        tick(3);

        // Speed changes
        bus.speed_sel = 2'd3;
        tick(10);
        check("spd_active3", bus.speed_active, 3);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin tick(1); cnt += int'(bus.cpu_ce); end
        check("spd_div4_pulses", cnt, 10);
        bus.speed_sel = 2'd1;
        tick(10);
        check("spd_active1", bus.speed_active, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin tick(1); cnt += int'(bus.cpu_ce); end
        check("spd_div2_pulses", cnt, 10);

        // Pause
        bus.speed_sel = 2'd2;
        tick(10);
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick(1);
            if (m_since == 1) found = 1;
        end
        check("pause_align_found", found, 1);
        bus.pause = 1'b1;
        tick(2);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(1); cnt += int'(bus.cpu_ce); end
        check("pause_no_ce", cnt, 0);
        bus.pause = 1'b0;
        tick(4);
        check("pause_resume_wait", bus.cpu_ce, 0);
        tick(1);
        check("pause_resume_pulse", bus.cpu_ce, 1);

        // Pause ignored during core reset
        bus.speed_sel = 2'd0;
        tick(5);
        bus.rst_src = 2'b01;
        bus.pause   = 1'b1;
        tick(4);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(1); cnt += int'(bus.cpu_ce); end
        check("pause_in_reset_ce", cnt, 8);
        bus.pause     = 1'b0;
        bus.rst_src   = 2'b00;
        bus.speed_sel = 2'd3;
        tick(5);
        check("pre_async_reset_out", bus.reset_out, 1);
        check("pre_async_speed", bus.speed_active, 3);

        // Asynchronous reset mid-stretch, taken while cpu_ce is high
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(1);
            if (bus.cpu_ce === 1'b1) found = 1;
        end
        check("async_ce_found", found, 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_out", bus.reset_out, 1);
        check("async_cpu_ce", bus.cpu_ce, 0);
        check("async_speed_active", bus.speed_active, 0);
        tick(3);
        reset_n = 1'b1;
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
